alu_seg_display: RTL

- Downstream consumer of the 4-bit switch ALU: captures a result word and its flags, then drives a 4-digit multiplexed, active-low seven-segment display.
- Arithmetic ops (000 add, 001 sub) are shown as signed decimal; all other ops are shown as hex.
- Carry is shown as 'C', overflow as the decimal point plus a whole-display blink, and the op code on the leftmost digit.
- Replaces raw LED output on the board top.

---
 rtl/alu_disp_pkg.sv | 33 +++
 rtl/seg_hex_decode.sv | 37 +++
 rtl/alu_seg_display.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_disp_pkg.sv
// alu_disp_pkg: op codes and active-low glyph constants
// shared by the ALU result display block.
package alu_disp_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C_HEX = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: 4-bit nibble to active-low
// gfedcba glyph, decimal point not included.
module seg_hex_decode
  import alu_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  logic [7:0] code;

  // nibble to full glyph code, dp bit dropped below
  always_comb begin
    code = SEG_BLANK;
    unique case (nib)
      4'h0: code = SEG_0;
      4'h1: code = SEG_1;
      4'h2: code = SEG_2;
      4'h3: code = SEG_3;
      4'h4: code = SEG_4;
      4'h5: code = SEG_5;
      4'h6: code = SEG_6;
      4'h7: code = SEG_7;
      4'h8: code = SEG_8;
      4'h9: code = SEG_9;
      4'hA: code = SEG_A;
      4'hB: code = SEG_B;
      4'hC: code = SEG_C_HEX;
      4'hD: code = SEG_D;
      4'hE: code = SEG_E;
      4'hF: code = SEG_F;
    endcase
  end

  assign glyph = code[6:0];

endmodule

// File: rtl/alu_seg_display.sv
// alu_seg_display: captures ALU result/flags and
// drives a 4-digit multiplexed active-low display.
module alu_seg_display
  import alu_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 4,
  parameter int BLINK_DIV   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_op,
  input  logic [3:0] in_res,
  input  logic       in_cout,
  input  logic       in_ovf,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ?
                      $clog2(BLINK_DIV) : 1;

  localparam logic [RW-1:0] CNT_MAX =
    RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] GUARD_C =
    RW'(GUARD);
  localparam logic [BW-1:0] SCAN_MAX =
    BW'(BLINK_DIV - 1);

  logic [2:0]    op_q;
  logic [3:0]    res_q;
  logic          cout_q;
  logic          ovf_q;

  logic [RW-1:0] cnt;
  logic [1:0]    slot;
  logic [BW-1:0] scan;
  logic          phase;

  logic          wrap;
  logic          neg;
  logic [4:0]    mag_full;
  logic [3:0]    mag;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic [7:0]    seg_d;
  logic [3:0]    an_d;

  // capture registers, loaded on every strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (in_valid) begin
      op_q   <= in_op;
      res_q  <= in_res;
      cout_q <= in_cout;
      ovf_q  <= in_ovf;
    end
  end

  assign wrap = (cnt == CNT_MAX);

  // refresh counter, slot index, scan count, blink phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      slot  <= '0;
      scan  <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      slot <= slot + 2'd1;
      if (slot == 2'd3) begin
        if (scan == SCAN_MAX) begin
          scan  <= '0;
          phase <= ~phase;
        end else begin
          scan <= scan + BW'(1);
        end
      end
    end else begin
      cnt <= cnt + RW'(1);
    end
  end

  assign neg      = is_arith(op_q) & res_q[3];
  assign mag_full = 5'd0 - {1'b0, res_q};
  assign mag      = neg ? mag_full[3:0] : res_q;

  // nibble routed to the shared decoder per slot
  always_comb begin
    nib = mag;
    if (slot == 2'd3) nib = {1'b0, op_q};
  end

  seg_hex_decode u_dec (
    .nib   (nib),
    .glyph (glyph)
  );

  // slot content: digit, sign, carry, op code
  always_comb begin
    seg_d = SEG_BLANK;
    unique case (slot)
      2'd0: seg_d = {~ovf_q, glyph};
      2'd1: seg_d = neg ? SEG_MINUS : SEG_BLANK;
      2'd2: seg_d = cout_q ? SEG_C : SEG_BLANK;
      2'd3: seg_d = {1'b1, glyph};
    endcase
  end

  // anode select with guard and overflow blink
  always_comb begin
    an_d = ~(4'b0001 << slot);
    if (cnt < GUARD_C) an_d = 4'hF;
    if (ovf_q && phase) an_d = 4'hF;
  end

  // segments and anodes change on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      seg <= seg_d;
      an  <= an_d;
    end
  end

endmodule
